// File: rtl/codec_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : codec_i2c_pkg
// Purpose  : Shared types and constants for the CODEC-side I2C register target.
// Revision : 1.0 - initial release
// ============================================================================
package codec_i2c_pkg;

    localparam int c_addr_w = 7;
    localparam int c_reg_w  = 9;
    localparam int c_byte_w = 8;

    localparam logic [c_addr_w-1:0] c_codec_dev_addr = 7'h1A;
    localparam logic [c_addr_w-1:0] c_reset_reg_addr = 7'h0F;

    localparam logic [3:0] c_bits_per_byte = 4'd8;
    localparam logic [2:0] c_msb_idx       = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEV_ADDR = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_line_monitor.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_monitor
// Purpose  : Synchronises SCL/SDA and flags SCL edges plus START/STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_line_monitor (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic scl_level,
    output logic sda_level
);

    // [0] first sync stage, [1] second sync stage, [2] history
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_i};
        sda_pipe_d = {sda_pipe_q[1:0], sda_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    assign scl_level = scl_pipe_q[1];
    assign sda_level = sda_pipe_q[1];
    assign scl_rise  =  scl_pipe_q[1] & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_pipe_q[1] &  scl_pipe_q[2];
    assign start_det =  scl_pipe_q[1] &  scl_pipe_q[2] &  sda_pipe_q[2] & ~sda_pipe_q[1];
    assign stop_det  =  scl_pipe_q[1] &  scl_pipe_q[2] & ~sda_pipe_q[2] &  sda_pipe_q[1];

endmodule
`default_nettype wire

// File: rtl/i2c_codec_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_target
// Purpose  : I2C target emulating the audio CODEC 9-bit register file.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_codec_target
    import codec_i2c_pkg::*;
#(
    parameter logic [c_addr_w-1:0] DEV_ADDR       = c_codec_dev_addr,
    parameter int                  NUM_REGS       = 32,
    parameter logic [c_addr_w-1:0] RESET_REG_ADDR = c_reset_reg_addr
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i2c_scl_i,
    input  logic                i2c_sda_i,
    output logic                i2c_sda_o,
    output logic                i2c_sda_t,
    output logic                wr_valid,
    output logic [c_addr_w-1:0] wr_addr,
    output logic [c_reg_w-1:0]  wr_data,
    output logic                busy
);

    localparam int                  c_idx_w    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [c_addr_w:0]   c_num_regs = (c_addr_w + 1)'(NUM_REGS);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_scl_level, w_sda_level;

    i2c_line_monitor u_line_monitor (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (i2c_scl_i),
        .sda_i     (i2c_sda_i),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .scl_level (w_scl_level),
        .sda_level (w_sda_level)
    );

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [c_byte_w-1:0]   shreg_q, shreg_d;
    logic [c_addr_w-1:0]   ptr_q, ptr_d;
    logic                  d8_q, d8_d;
    logic                  byte_idx_q, byte_idx_d;
    logic                  rw_q, rw_d;
    logic                  sda_t_q, sda_t_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [c_addr_w-1:0]   wr_addr_q, wr_addr_d;
    logic [c_reg_w-1:0]    wr_data_q, wr_data_d;
    logic [c_reg_w-1:0]    regs_q [NUM_REGS];
    logic [c_reg_w-1:0]    regs_d [NUM_REGS];

    logic                  w_drive_slot;
    logic                  w_ptr_in_range;
    logic [c_idx_w-1:0]    w_ptr_idx;
    logic [c_reg_w-1:0]    w_rd_word;
    logic [c_byte_w-1:0]   w_rd_byte0, w_rd_byte1, w_rd_byte;
    logic [c_reg_w-1:0]    w_commit_data;

    // SDA may only move while SCL is low
    assign w_drive_slot   = w_scl_fall & ~w_scl_level;
    assign w_ptr_in_range = ({1'b0, ptr_q} < c_num_regs);
    assign w_ptr_idx      = ptr_q[c_idx_w-1:0];
    assign w_rd_word      = w_ptr_in_range ? regs_q[w_ptr_idx] : '0;
    assign w_rd_byte0     = {{(c_byte_w-1){1'b0}}, w_rd_word[c_reg_w-1]};
    assign w_rd_byte1     = w_rd_word[c_byte_w-1:0];
    assign w_rd_byte      = byte_idx_q ? w_rd_byte1 : w_rd_byte0;
    assign w_commit_data  = {d8_q, shreg_q};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        d8_d       = d8_q;
        byte_idx_d = byte_idx_q;
        rw_d       = rw_q;
        sda_t_d    = sda_t_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        if (w_start) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_t_d   = 1'b1;
        end else if (w_stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            sda_t_d = 1'b1;
        end else begin
            case (state_q)
                ST_DEV_ADDR: begin
                    if (w_scl_rise && bit_cnt_q != c_bits_per_byte) begin
                        shreg_d   = {shreg_q[c_byte_w-2:0], w_sda_level};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (w_drive_slot && bit_cnt_q == c_bits_per_byte) begin
                        if (shreg_q[c_byte_w-1:1] == DEV_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            sda_t_d = 1'b0;
                            busy_d  = 1'b1;
                            rw_d    = shreg_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_drive_slot) begin
                        bit_cnt_d  = 4'd0;
                        byte_idx_d = 1'b0;
                        if (rw_q) begin
                            state_d = ST_RD_BYTE;
                            sda_t_d = w_rd_byte0[c_msb_idx];
                        end else begin
                            state_d = ST_WR_BYTE;
                            sda_t_d = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (w_scl_rise && bit_cnt_q != c_bits_per_byte) begin
                        shreg_d   = {shreg_q[c_byte_w-2:0], w_sda_level};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (w_drive_slot && bit_cnt_q == c_bits_per_byte) begin
                        state_d    = ST_WR_ACK;
                        sda_t_d    = 1'b0;
                        byte_idx_d = ~byte_idx_q;
                        if (!byte_idx_q) begin
                            ptr_d = shreg_q[c_byte_w-1:1];
                            d8_d  = shreg_q[0];
                        end else if (ptr_q == RESET_REG_ADDR) begin
                            // soft reset clears the whole file; the write itself is still reported
                            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = w_commit_data;
                        end else if (w_ptr_in_range) begin
                            regs_d[w_ptr_idx] = w_commit_data;
                            wr_valid_d        = 1'b1;
                            wr_addr_d         = ptr_q;
                            wr_data_d         = w_commit_data;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (w_drive_slot) begin
                        state_d   = ST_WR_BYTE;
                        bit_cnt_d = 4'd0;
                        sda_t_d   = 1'b1;
                    end
                end
                ST_RD_BYTE: begin
                    if (w_scl_rise && bit_cnt_q != c_bits_per_byte) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (w_drive_slot) begin
                        if (bit_cnt_q == c_bits_per_byte) begin
                            state_d = ST_RD_ACK;
                            sda_t_d = 1'b1;
                        end else begin
                            sda_t_d = w_rd_byte[c_msb_idx - bit_cnt_q[2:0]];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_level) begin
                            state_d = ST_IGNORE;
                        end else begin
                            state_d    = ST_RD_BYTE;
                            bit_cnt_d  = 4'd0;
                            byte_idx_d = ~byte_idx_q;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_t_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_t_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            d8_q       <= 1'b0;
            byte_idx_q <= 1'b0;
            rw_q       <= 1'b0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            d8_q       <= d8_d;
            byte_idx_q <= byte_idx_d;
            rw_q       <= rw_d;
            sda_t_q    <= sda_t_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = sda_t_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_codec_target
// Purpose  : Self-checking bench: bit-banged I2C master plus register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_target;

    localparam int T = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       bus_sda;
    logic       i2c_sda_o, i2c_sda_t, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;

    assign bus_sda = m_sda & (i2c_sda_t | i2c_sda_o);

    i2c_codec_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i2c_scl_i (m_scl),
        .i2c_sda_i (bus_sda),
        .i2c_sda_o (i2c_sda_o),
        .i2c_sda_t (i2c_sda_t),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_log[$];
    always @(negedge clk) if (wr_valid === 1'b1) wr_log.push_back({wr_addr, wr_data});

    // transaction-level model of the register file
    logic [8:0]  m_regs[128];
    logic [6:0]  m_ptr;
    logic        m_d8;
    logic [15:0] m_exp[$];

    typedef struct {
        logic [7:0] dev;
        logic [6:0] reg_a;
        logic [8:0] data;
        logic [6:0] rb_reg;
        logic       exp_ack;
        logic       exp_wr;
        logic [8:0] exp_rb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_ptr = '0;
        m_d8  = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] bytes[$]);
        for (int i = 0; i < bytes.size(); i++) begin
            logic [7:0] b;
            b = bytes[i];
            if (i % 2 == 0) begin
                m_ptr = b[7:1];
                m_d8  = b[0];
            end else if (m_ptr == 7'h0F) begin
                foreach (m_regs[j]) m_regs[j] = '0;
                m_exp.push_back({m_ptr, m_d8, b});
            end else if (m_ptr < 7'd32) begin
                m_regs[m_ptr] = {m_d8, b};
                m_exp.push_back({m_ptr, m_d8, b});
            end
        end
    endtask

    function automatic logic [7:0] model_rd(input int k);
        logic [8:0] w;
        w = (m_ptr < 7'd32) ? m_regs[m_ptr] : 9'h000;
        return (k % 2 == 0) ? {7'b0, w[8]} : w[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic s);
        tick(2);
        m_sda = b;
        tick(T);
        m_scl = 1'b1;
        tick(T);
        s = bus_sda;
        m_scl = 1'b0;
    endtask

    task automatic m_start();
        tick(2);
        m_sda = 1'b1;
        tick(T);
        m_scl = 1'b1;
        tick(T);
        m_sda = 1'b0;
        tick(T);
        m_scl = 1'b0;
    endtask

    task automatic m_stop();
        tick(2);
        m_sda = 1'b0;
        tick(T);
        m_scl = 1'b1;
        tick(T);
        m_sda = 1'b1;
        tick(T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            b[i] = s;
        end
        m_bit(nack, s);
    endtask

    task automatic do_write(input logic [7:0] dev, input logic [7:0] bytes[$],
                            output logic addr_ack, output int acks);
        m_start();
        write_byte(dev, addr_ack);
        chk("busy_after_addr", {31'b0, busy}, (dev[7:1] == 7'h1A) ? 32'd1 : 32'd0);
        acks = 0;
        if (addr_ack) begin
            foreach (bytes[i]) begin
                logic a;
                write_byte(bytes[i], a);
                if (a) acks++;
            end
        end
        m_stop();
        chk("busy_after_stop", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [6:0] ra, input int n,
                           output logic [7:0] rd[$]);
        logic       a;
        logic [7:0] b;
        rd.delete();
        m_start();
        if (set_ptr) begin
            write_byte(8'h34, a);
            chk("rd_wr_addr_ack", {31'b0, a}, 32'd1);
            write_byte({ra, 1'b0}, a);
            chk("rd_ptr_ack", {31'b0, a}, 32'd1);
            m_ptr = ra;
            m_d8  = 1'b0;
            m_start();
        end
        write_byte(8'h35, a);
        chk("rd_addr_ack", {31'b0, a}, 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(b, (k == n - 1));
            rd.push_back(b);
        end
        m_stop();
    endtask

    task automatic check_wr_events(input int n0);
        chk("wr_count", wr_log.size() - n0, m_exp.size());
        for (int i = 0; i < m_exp.size() && (n0 + i) < wr_log.size(); i++)
            chk("wr_event", {16'b0, wr_log[n0 + i]}, {16'b0, m_exp[i]});
    endtask

    task automatic model_read_check(input logic set_ptr, input logic [6:0] ra, input int n);
        logic [7:0] rd[$];
        int         n0;
        n0 = wr_log.size();
        do_read(set_ptr, ra, n, rd);
        for (int k = 0; k < n; k++) chk("rd_byte", {24'b0, rd[k]}, {24'b0, model_rd(k)});
        chk("rd_no_wr", wr_log.size() - n0, 0);
    endtask

    initial begin
        vec_t       vecs[8];
        logic [7:0] bq[$];
        logic [7:0] rd[$];
        logic       ack;
        int         acks;
        int         n0;

        vecs[0] = '{8'h34, 7'h04, 9'h012, 7'h04, 1'b1, 1'b1, 9'h012};
        vecs[1] = '{8'h36, 7'h04, 9'h1FF, 7'h04, 1'b0, 1'b0, 9'h012};
        vecs[2] = '{8'h34, 7'h04, 9'h1FF, 7'h04, 1'b1, 1'b1, 9'h1FF};
        vecs[3] = '{8'h34, 7'h0F, 9'h000, 7'h04, 1'b1, 1'b1, 9'h000};
        vecs[4] = '{8'h34, 7'h7F, 9'h155, 7'h7F, 1'b1, 1'b0, 9'h000};
        vecs[5] = '{8'h34, 7'h1F, 9'h1AB, 7'h1F, 1'b1, 1'b1, 9'h1AB};
        vecs[6] = '{8'h34, 7'h20, 9'h0AA, 7'h20, 1'b1, 1'b0, 9'h000};
        vecs[7] = '{8'h34, 7'h00, 9'h100, 7'h00, 1'b1, 1'b1, 9'h100};

        model_reset();
        tick(5);
        chk("rst_sda_t",    {31'b0, i2c_sda_t}, 32'd1);
        chk("rst_sda_o",    {31'b0, i2c_sda_o}, 32'd0);
        chk("rst_wr_valid", {31'b0, wr_valid},  32'd0);
        chk("rst_wr_addr",  {25'b0, wr_addr},   32'd0);
        chk("rst_wr_data",  {23'b0, wr_data},   32'd0);
        chk("rst_busy",     {31'b0, busy},      32'd0);
        reset_n = 1'b1;
        tick(5);

        for (int v = 0; v < 8; v++) begin
            bq.delete();
            bq.push_back({vecs[v].reg_a, vecs[v].data[8]});
            bq.push_back(vecs[v].data[7:0]);
            n0 = wr_log.size();
            do_write(vecs[v].dev, bq, ack, acks);
            chk("vec_addr_ack", {31'b0, ack}, {31'b0, vecs[v].exp_ack});
            if (vecs[v].exp_ack) begin
                chk("vec_data_acks", acks, 2);
                model_write(bq);
            end
            chk("vec_wr_count", wr_log.size() - n0, {31'b0, vecs[v].exp_wr});
            if (vecs[v].exp_wr && wr_log.size() > n0)
                chk("vec_wr_event", {16'b0, wr_log[n0]}, {16'b0, vecs[v].reg_a, vecs[v].data});
            n0 = wr_log.size();
            do_read(1'b1, vecs[v].rb_reg, 2, rd);
            chk("vec_rb_hi", {25'b0, rd[0][7:1]}, 32'd0);
            chk("vec_rb", {23'b0, rd[0][0], rd[1]}, {23'b0, vecs[v].exp_rb});
            chk("vec_rb_no_wr", wr_log.size() - n0, 0);
            m_exp.delete();
        end

        // a third byte starts a new pair: two commits in one transfer
        bq.delete();
        bq.push_back(8'h08); bq.push_back(8'hAB); bq.push_back(8'h0A); bq.push_back(8'h55);
        n0 = wr_log.size();
        do_write(8'h34, bq, ack, acks);
        chk("pair_acks", acks, 4);
        chk("pair_cnt", wr_log.size() - n0, 2);
        if (wr_log.size() >= n0 + 2) begin
            chk("pair_ev0", {16'b0, wr_log[n0]},     {16'b0, 7'h04, 9'h0AB});
            chk("pair_ev1", {16'b0, wr_log[n0 + 1]}, {16'b0, 7'h05, 9'h055});
        end
        model_write(bq);
        m_exp.delete();
        // ACK, ACK, ACK, NACK: the byte pair repeats without pointer increment
        model_read_check(1'b1, 7'h05, 4);

        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                int npairs;
                npairs = $urandom_range(1, 2);
                bq.delete();
                for (int p = 0; p < npairs; p++) begin
                    int         sel;
                    logic [6:0] ra;
                    logic [8:0] d;
                    sel = $urandom_range(0, 9);
                    if (sel < 7)       ra = 7'($urandom_range(0, 31));
                    else if (sel == 7) ra = 7'h0F;
                    else if (sel == 8) ra = 7'($urandom_range(32, 127));
                    else               ra = 7'h1F;
                    d = 9'($urandom_range(0, 511));
                    bq.push_back({ra, d[8]});
                    bq.push_back(d[7:0]);
                end
                if ($urandom_range(0, 3) == 0) bq.push_back(8'($urandom_range(0, 255)));
                m_exp.delete();
                n0 = wr_log.size();
                do_write(8'h34, bq, ack, acks);
                chk("rnd_addr_ack", {31'b0, ack}, 32'd1);
                chk("rnd_data_acks", acks, bq.size());
                model_write(bq);
                check_wr_events(n0);
                m_exp.delete();
            end else begin
                model_read_check(op == 1, 7'($urandom_range(0, 40)), $urandom_range(1, 4));
            end
        end

        // put known non-zero content in place, then reset while the target ACKs
        bq.delete();
        bq.push_back(8'h0B); bq.push_back(8'h55);
        do_write(8'h34, bq, ack, acks);
        model_write(bq);
        m_exp.delete();
        begin
            logic [7:0] adr;
            logic       s;
            int         w;
            adr = 8'h34;
            m_start();
            for (int i = 7; i >= 0; i--) m_bit(adr[i], s);
            w = 0;
            while (i2c_sda_t !== 1'b0 && w < 40) begin
                tick(1);
                w++;
            end
            chk("mid_ack_driven", {31'b0, i2c_sda_t}, 32'd0);
            #1 reset_n = 1'b0;
            #1;
            chk("mid_rst_sda_t", {31'b0, i2c_sda_t}, 32'd1);
            chk("mid_rst_busy",  {31'b0, busy},      32'd0);
            tick(3);
            m_scl = 1'b1;
            m_sda = 1'b1;
            tick(3);
            reset_n = 1'b1;
            tick(5);
        end
        model_reset();
        model_read_check(1'b0, 7'h00, 2);
        model_read_check(1'b1, 7'h05, 2);
        model_read_check(1'b1, 7'h1F, 2);
        model_read_check(1'b1, 7'h04, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not reach summary, bound expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
